// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM state encodings and control-field encodings for mc_control.
// ADDI states exist only when MC_CONTROL_ADDI_EN is defined.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
`ifdef MC_CONTROL_ADDI_EN
    ,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctl_t;

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: maps FSM state and mem_ready to the datapath control word.
// Purely combinational; reset gating is applied by the parent.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    unique case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCS_ALU;
        // IR and PC only load on the cycle the read completes
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SL2;
        ctl.alu_op    = ALU_ADD;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_MEM_ADDR, S_ADDI_EXEC: begin
`else
      S_MEM_ADDR: begin
`endif
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCS_JUMP;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM with retire counter and illegal-op flag.
// Define MC_CONTROL_ADDI_EN to decode ADDI; otherwise ADDI is illegal.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       state
);

  state_t           state_q;
  state_t           state_d;
  logic             is_sw_q;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;
  ctl_t             ctl;
  ctl_t             ctl_g;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_sw_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // remember LW vs SW so later opcode changes are ignored
      if (state_q == S_DECODE) is_sw_q <= (opcode == OP_SW);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    unique case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
`endif
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP:
                   state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  // entries from IDLE, FETCH stalls and illegal DECODE do not retire
  assign retire = (state_d == S_FETCH) &&
                  (state_q != S_IDLE) &&
                  (state_q != S_FETCH) &&
                  (state_q != S_DECODE);

  mc_out_decode u_out (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  assign ctl_g = rst_n ? ctl : '0;

  assign pc_write      = ctl_g.pc_write;
  assign pc_write_cond = ctl_g.pc_write_cond;
  assign pc_source     = ctl_g.pc_source;
  assign i_or_d        = ctl_g.i_or_d;
  assign mem_read      = ctl_g.mem_read;
  assign mem_write     = ctl_g.mem_write;
  assign ir_write      = ctl_g.ir_write;
  assign reg_dst       = ctl_g.reg_dst;
  assign mem_to_reg    = ctl_g.mem_to_reg;
  assign reg_write     = ctl_g.reg_write;
  assign alu_src_a     = ctl_g.alu_src_a;
  assign alu_src_b     = ctl_g.alu_src_b;
  assign alu_op        = ctl_g.alu_op;
  assign illegal_op    = rst_n & illegal;
  assign instr_retired = cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed plus random instruction traces checked against
// a per-instruction state-path model and the control-output table.
module tb_mc_control;

  localparam logic [5:0] R_OP  = 6'b000000;
  localparam logic [5:0] LW_OP = 6'b100011;
  localparam logic [5:0] SW_OP = 6'b101011;
  localparam logic [5:0] BQ_OP = 6'b000100;
  localparam logic [5:0] J_OP  = 6'b000010;
  localparam logic [5:0] AI_OP = 6'b001000;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_op;
  logic        illegal_op;
  logic [31:0] instr_retired;
  logic [3:0]  state;

  int          tests;
  int          fails;
  logic [31:0] exp_cnt;

  mc_control #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(logic [5:0] op);
    bit ok;
    ok = (op == R_OP) || (op == LW_OP) || (op == SW_OP) ||
         (op == BQ_OP) || (op == J_OP);
`ifdef MC_CONTROL_ADDI_EN
    ok = ok || (op == AI_OP);
`endif
    return ok;
  endfunction

  // Control table: {pw,pwc,pcs,iod,mrd,mwr,irw,rdst,m2r,rw,asa,asb,aop}
  function automatic logic [16:0] exp_ctl(int st, bit mr);
    logic       pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    pcs = 2'b00;
    asb = 2'b00;
    aop = 3'b000;
    case (st)
      1: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      2: asb = 2'b11;
      3, 11: begin asa = 1; asb = 2'b10; end
      4: begin mrd = 1; iod = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mwr = 1; iod = 1; end
      7: begin asa = 1; aop = 3'b010; end
      8: begin rw = 1; rdst = 1; end
      9: begin asa = 1; aop = 3'b001; pwc = 1; pcs = 2'b01; end
      10: begin pw = 1; pcs = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, pcs, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  task automatic cyc(input int st, input bit mr, input logic [5:0] op,
                     input bit ill, input bit rst);
    logic [16:0] ec;
    logic [16:0] oc;
    @(negedge clk);
    rst_n     = rst;
    mem_ready = mr;
    opcode    = op;
    #1;
    ec = rst ? exp_ctl(st, mr) : 17'd0;
    oc = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
          ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
          alu_op};
    chk("state", {28'd0, state}, 32'(st));
    chk("ctl", {15'd0, oc}, {15'd0, ec});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, ill & rst});
    chk("instr_retired", instr_retired, exp_cnt);
  endtask

  // One instruction: fs FETCH stalls, ms memory-stage stalls
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    bit ok;
    ok = is_legal(op);
    for (int i = 0; i < fs; i++) cyc(1, 0, rop(), 0, 1);
    cyc(1, 1, rop(), 0, 1);
    cyc(2, rbit(), op, !ok, 1);
    if (ok) begin
      case (op)
        LW_OP: begin
          cyc(3, rbit(), rop(), 0, 1);
          for (int i = 0; i < ms; i++) cyc(4, 0, rop(), 0, 1);
          cyc(4, 1, rop(), 0, 1);
          cyc(5, rbit(), rop(), 0, 1);
        end
        SW_OP: begin
          cyc(3, rbit(), rop(), 0, 1);
          for (int i = 0; i < ms; i++) cyc(6, 0, rop(), 0, 1);
          cyc(6, 1, rop(), 0, 1);
        end
        R_OP: begin
          cyc(7, rbit(), rop(), 0, 1);
          cyc(8, rbit(), rop(), 0, 1);
        end
        BQ_OP: cyc(9, rbit(), rop(), 0, 1);
        J_OP:  cyc(10, rbit(), rop(), 0, 1);
        default: begin
          cyc(11, rbit(), rop(), 0, 1);
          cyc(12, rbit(), rop(), 0, 1);
        end
      endcase
      exp_cnt = exp_cnt + 32'd1;
    end
  endtask

  initial begin
    logic [5:0] op;
    int         sel;
    tests     = 0;
    fails     = 0;
    exp_cnt   = 32'd0;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'd0;
    @(posedge clk);
    cyc(0, 1, 6'h3f, 0, 0);
    cyc(0, 1, 6'h00, 0, 0);
    cyc(0, 1, 6'h00, 0, 1);

    run_instr(R_OP, 0, 0);
    run_instr(LW_OP, 0, 2);
    run_instr(SW_OP, 1, 2);
    run_instr(BQ_OP, 0, 0);
    run_instr(J_OP, 2, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(AI_OP, 0, 0);
    run_instr(R_OP, 0, 0);

    cyc(1, 1, rop(), 0, 1);
    cyc(2, 1, SW_OP, 0, 1);
    cyc(3, 1, rop(), 0, 1);
    cyc(6, 0, rop(), 0, 1);
    cyc(6, 0, rop(), 0, 0);
    exp_cnt = 32'd0;
    cyc(0, 0, rop(), 0, 0);
    cyc(0, 1, rop(), 0, 1);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = R_OP;
        1: op = LW_OP;
        2: op = SW_OP;
        3: op = BQ_OP;
        4: op = J_OP;
        5: op = AI_OP;
        default: begin
          op = rop();
          while (is_legal(op) || op == AI_OP) op = rop();
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    cyc(1, 0, rop(), 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
